ram_master: RTL and testbench

- Initiator-side controller for the single-port RAM. It drives the RAM address, write-enable (set) and write-data lines, and samples the RAM read data.
- It accepts one command at a time from the processor datapath or a debug loader over a valid/ready handshake. Commands are single-word WRITE, multi-word FILL with a constant, and multi-word READ burst.
- READ burst words are streamed back to the requester with backpressure.

---
 rtl/ram_master_if.sv | 37 +++
 rtl/ram_master.sv | 92 +++++++++
 tb/tb_ram_master.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_master_if.sv
// ram_master_if: command, read-response and RAM-side signals of the RAM initiator
//   request : i_req_valid, o_req_ready, i_req_op, i_req_addr, i_req_len, i_req_data
//   response: o_rsp_valid, i_rsp_ready, o_rsp_data, o_rsp_last, o_done, o_err
//   ram     : o_ram_addr, o_ram_set, o_ram_data, i_ram_data
//   modport master is the controller side, slave is the requester/RAM side
interface ram_master_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 8
);
   logic              i_req_valid;
   logic              o_req_ready;
   logic [1:0]        i_req_op;
   logic [ADDR_W-1:0] i_req_addr;
   logic [LEN_W-1:0]  i_req_len;
   logic [DATA_W-1:0] i_req_data;
   logic              o_rsp_valid;
   logic              i_rsp_ready;
   logic [DATA_W-1:0] o_rsp_data;
   logic              o_rsp_last;
   logic              o_done;
   logic              o_err;
   logic [ADDR_W-1:0] o_ram_addr;
   logic              o_ram_set;
   logic [DATA_W-1:0] o_ram_data;
   logic [DATA_W-1:0] i_ram_data;
   modport master (
      input  i_req_valid, i_req_op, i_req_addr, i_req_len, i_req_data, i_rsp_ready, i_ram_data,
      output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_last, o_done, o_err,
             o_ram_addr, o_ram_set, o_ram_data
   );
   modport slave (
      output i_req_valid, i_req_op, i_req_addr, i_req_len, i_req_data, i_rsp_ready, i_ram_data,
      input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_last, o_done, o_err,
             o_ram_addr, o_ram_set, o_ram_data
   );
endinterface

// File: rtl/ram_master.sv
// ram_master: single-port RAM initiator running WRITE, FILL and READ-burst commands
//   i_clk : clock, rising edge
//   i_rst : synchronous active-high reset
//   bus   : ram_master_if.master carrying request, response and RAM signals
module ram_master #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 8,
   parameter int RD_LAT = 1
) (
   input logic          i_clk,
   input logic          i_rst,
   ram_master_if.master bus
);
   typedef enum logic [2:0] {IDLE, WR, FILL, RD_WAIT, RD_HOLD, FIN} state_t;
   localparam int WW = RD_LAT > 0 ? $clog2(RD_LAT + 1) : 1;
   state_t           state, nxt;
   logic [LEN_W-1:0] cnt;
   logic [WW-1:0]    w;
   logic             acc, last_one, cap;
   logic             nxt_ready, nxt_set, nxt_valid, nxt_done, nxt_err;
   assign acc      = bus.i_req_valid & bus.o_req_ready;
   assign last_one = cnt == LEN_W'(1);
   assign cap      = w == WW'(RD_LAT);
   // outputs are registered: the output decode looks at the next state
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state           <= IDLE;
         cnt             <= '0;
         w               <= '0;
         bus.o_req_ready <= 1'b1;
         bus.o_ram_set   <= 1'b0;
         bus.o_rsp_valid <= 1'b0;
         bus.o_done      <= 1'b0;
         bus.o_err       <= 1'b0;
         bus.o_rsp_last  <= 1'b0;
         bus.o_rsp_data  <= DATA_W'(0);
         bus.o_ram_data  <= DATA_W'(0);
         bus.o_ram_addr  <= ADDR_W'(0);
      end else begin
         state           <= nxt;
         bus.o_req_ready <= nxt_ready;
         bus.o_ram_set   <= nxt_set;
         bus.o_rsp_valid <= nxt_valid;
         bus.o_done      <= nxt_done;
         bus.o_err       <= nxt_err;
         case (state)
            IDLE: if (acc) begin
               bus.o_ram_addr <= bus.i_req_addr;
               bus.o_ram_data <= bus.i_req_data;
               cnt            <= bus.i_req_len;
            end
            FILL: if (!last_one) begin
               bus.o_ram_addr <= bus.o_ram_addr + ADDR_W'(1);
               cnt            <= cnt - LEN_W'(1);
            end
            RD_WAIT: begin
               w <= cap ? '0 : w + WW'(1);
               if (cap) begin
                  bus.o_rsp_data <= bus.i_ram_data;
                  bus.o_rsp_last <= last_one;
               end
            end
            RD_HOLD: if (bus.i_rsp_ready && !last_one) begin
               bus.o_ram_addr <= bus.o_ram_addr + ADDR_W'(1);
               cnt            <= cnt - LEN_W'(1);
            end
            default: ;
         endcase
      end
   end
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (acc) nxt = bus.i_req_op == 2'b01 ? WR :
                                 (bus.i_req_op == 2'b11 || bus.i_req_len == '0) ? FIN :
                                 bus.i_req_op == 2'b10 ? FILL : RD_WAIT;
         WR:      nxt = FIN;
         FILL:    nxt = last_one ? FIN : FILL;
         RD_WAIT: nxt = cap ? RD_HOLD : RD_WAIT;
         RD_HOLD: if (bus.i_rsp_ready) nxt = last_one ? FIN : RD_WAIT;
         default: nxt = IDLE;
      endcase
   end
   always_comb begin
      nxt_ready = nxt == IDLE;
      nxt_set   = nxt == WR || nxt == FILL;
      nxt_valid = nxt == RD_HOLD;
      nxt_done  = nxt == FIN;
      nxt_err   = state == IDLE && acc && bus.i_req_op == 2'b11;
   end
endmodule

// File: tb/tb_ram_master.sv
// tb_ram_master: directed self-checking bench for ram_master with a 1-cycle-latency RAM model
module tb_ram_master;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          vec = 0;
   int          mis = 0;
   logic [31:0] mem [0:65535];
   logic [31:0] rd = '0;
   ram_master_if #(.ADDR_W(16), .DATA_W(32), .LEN_W(8)) bus();
   ram_master #(.ADDR_W(16), .DATA_W(32), .LEN_W(8), .RD_LAT(1)) dut (
      .i_clk(clk), .i_rst(rst), .bus(bus)
   );
   always #5 clk = ~clk;
   always @(posedge clk) begin
      if (bus.o_ram_set) mem[bus.o_ram_addr] <= bus.o_ram_data;
      rd <= mem[bus.o_ram_addr];
   end
   assign bus.i_ram_data = rd;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [7:0] l, input logic [31:0] d);
      bus.i_req_op    = op;
      bus.i_req_addr  = a;
      bus.i_req_len   = l;
      bus.i_req_data  = d;
      bus.i_req_valid = 1'b1;
      step();
      bus.i_req_valid = 1'b0;
      bus.i_req_op    = 2'b01;
      bus.i_req_addr  = 16'h5A5A;
      bus.i_req_len   = 8'hEE;
      bus.i_req_data  = 32'hBADBAD00;
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         step();
         ok = bus.o_rsp_valid;
      end
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         step();
         ok = bus.o_done;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      vec++;
      if ({bus.o_req_ready, bus.o_ram_set, bus.o_rsp_valid, bus.o_done, bus.o_err, bus.o_rsp_last} !== 6'b100000) begin
         mis++;
         $display("FAIL reset_ctrl got %b want 100000", {bus.o_req_ready, bus.o_ram_set, bus.o_rsp_valid, bus.o_done, bus.o_err, bus.o_rsp_last});
      end
      vec++;
      if ({bus.o_ram_addr, bus.o_ram_data, bus.o_rsp_data} !== 80'h0) begin
         mis++;
         $display("FAIL reset_data got %h %h %h want zeros", bus.o_ram_addr, bus.o_ram_data, bus.o_rsp_data);
      end
   endtask

   task automatic test_write(input logic [15:0] a, input logic [31:0] d);
      send(2'b01, a, 8'd0, d);
      vec++;
      if ({bus.o_ram_set, bus.o_req_ready, bus.o_done, bus.o_ram_addr, bus.o_ram_data} !== {3'b100, a, d}) begin
         mis++;
         $display("FAIL write_cycle got set=%b rdy=%b done=%b addr=%h data=%h want set=1 rdy=0 done=0 addr=%h data=%h",
                  bus.o_ram_set, bus.o_req_ready, bus.o_done, bus.o_ram_addr, bus.o_ram_data, a, d);
      end
      step();
      vec++;
      if ({bus.o_ram_set, bus.o_req_ready, bus.o_done, bus.o_err} !== 4'b0010) begin
         mis++;
         $display("FAIL write_fin got set/rdy/done/err=%b want 0010", {bus.o_ram_set, bus.o_req_ready, bus.o_done, bus.o_err});
      end
      step();
      vec++;
      if ({bus.o_req_ready, bus.o_done, mem[a]} !== {2'b10, d}) begin
         mis++;
         $display("FAIL write_idle got rdy=%b done=%b mem=%h want rdy=1 done=0 mem=%h", bus.o_req_ready, bus.o_done, mem[a], d);
      end
   endtask

   task automatic test_fill(input logic [15:0] a, input logic [7:0] l, input logic [31:0] d);
      logic [15:0] ea;
      bit ok;
      ea = a;
      send(2'b10, a, l, d);
      for (int i = 0; i < int'(l); i++) begin
         vec++;
         if ({bus.o_ram_set, bus.o_ram_addr, bus.o_ram_data, bus.o_done} !== {1'b1, ea, d, 1'b0}) begin
            mis++;
            $display("FAIL fill_word%0d got set=%b addr=%h data=%h done=%b want set=1 addr=%h data=%h done=0",
                     i, bus.o_ram_set, bus.o_ram_addr, bus.o_ram_data, bus.o_done, ea, d);
         end
         ea = ea + 16'd1;
         if (i < int'(l) - 1) step();
      end
      wait_done(ok);
      vec++;
      if (!ok || bus.o_ram_set !== 1'b0) begin
         mis++;
         $display("FAIL fill_done got done_seen=%b set=%b want 1 0", ok, bus.o_ram_set);
      end
      step();
   endtask

   task automatic test_fill_read();
      logic [31:0] exp [5];
      int n;
      bit ok;
      bit lasts [5];
      logic [31:0] got [5];
      exp = '{32'hAAAAAAAA, 32'h11111111, 32'h55555555, 32'h55555555, 32'h55555555};
      test_fill(16'h0002, 8'd3, 32'h55555555);
      vec++;
      if ({mem[2], mem[3], mem[4], mem[5]} !== {{3{32'h55555555}}, 32'h0}) begin
         mis++;
         $display("FAIL fill_mem got %h %h %h %h want 55555555 x3 then 0", mem[2], mem[3], mem[4], mem[5]);
      end
      bus.i_rsp_ready = 1'b1;
      send(2'b00, 16'h0000, 8'd5, 32'h0);
      n = 0;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         if (bus.o_ram_set) begin
            mis++;
            $display("FAIL read_set got set=1 want 0");
         end
         if (bus.o_rsp_valid) begin
            if (n < 5) begin
               got[n] = bus.o_rsp_data;
               lasts[n] = bus.o_rsp_last;
            end
            n++;
         end
         ok = bus.o_done;
         if (!ok) step();
      end
      vec++;
      if (!ok || n != 5) begin
         mis++;
         $display("FAIL read5_count got words=%0d done=%b want 5 1", n, ok);
      end
      for (int i = 0; i < 5 && i < n; i++) begin
         vec++;
         if ({got[i], lasts[i]} !== {exp[i], i == 4}) begin
            mis++;
            $display("FAIL read5_word%0d got %h last=%b want %h last=%b", i, got[i], lasts[i], exp[i], i == 4);
         end
      end
      step();
   endtask

   task automatic test_backpressure();
      bit ok;
      bus.i_rsp_ready = 1'b1;
      send(2'b00, 16'h0000, 8'd3, 32'h0);
      if (!bus.o_rsp_valid) wait_valid(ok); else ok = 1'b1;
      vec++;
      if (!ok || {bus.o_rsp_data, bus.o_rsp_last} !== {32'hAAAAAAAA, 1'b0}) begin
         mis++;
         $display("FAIL bp_word0 got ok=%b %h last=%b want AAAAAAAA last=0", ok, bus.o_rsp_data, bus.o_rsp_last);
      end
      wait_valid(ok);
      bus.i_rsp_ready = 1'b0;
      vec++;
      if (!ok || {bus.o_rsp_data, bus.o_rsp_last, bus.o_ram_addr} !== {32'h11111111, 1'b0, 16'h0001}) begin
         mis++;
         $display("FAIL bp_word1 got ok=%b %h last=%b addr=%h want 11111111 0 0001", ok, bus.o_rsp_data, bus.o_rsp_last, bus.o_ram_addr);
      end
      for (int i = 0; i < 4; i++) begin
         step();
         vec++;
         if ({bus.o_rsp_valid, bus.o_rsp_data, bus.o_rsp_last, bus.o_ram_addr} !== {1'b1, 32'h11111111, 1'b0, 16'h0001}) begin
            mis++;
            $display("FAIL bp_stall%0d got v=%b %h last=%b addr=%h want 1 11111111 0 0001",
                     i, bus.o_rsp_valid, bus.o_rsp_data, bus.o_rsp_last, bus.o_ram_addr);
         end
      end
      bus.i_rsp_ready = 1'b1;
      wait_valid(ok);
      vec++;
      if (!ok || {bus.o_rsp_data, bus.o_rsp_last, bus.o_ram_addr} !== {32'h55555555, 1'b1, 16'h0002}) begin
         mis++;
         $display("FAIL bp_word2 got ok=%b %h last=%b addr=%h want 55555555 1 0002", ok, bus.o_rsp_data, bus.o_rsp_last, bus.o_ram_addr);
      end
      step();
      vec++;
      if ({bus.o_rsp_valid, bus.o_done} !== 2'b01) begin
         mis++;
         $display("FAIL bp_fin got valid/done=%b want 01", {bus.o_rsp_valid, bus.o_done});
      end
      step();
   endtask

   task automatic test_wrap();
      test_fill(16'hFFFE, 8'd3, 32'h12345678);
      vec++;
      if ({mem[16'hFFFE], mem[16'hFFFF], mem[0], mem[1]} !== {{3{32'h12345678}}, 32'h11111111}) begin
         mis++;
         $display("FAIL wrap_mem got %h %h %h %h want 12345678 x3 then 11111111", mem[16'hFFFE], mem[16'hFFFF], mem[0], mem[1]);
      end
   endtask

   task automatic test_zero_len_reserved();
      send(2'b00, 16'h0010, 8'd0, 32'h0);
      vec++;
      if ({bus.o_done, bus.o_err, bus.o_ram_set, bus.o_rsp_valid, bus.o_req_ready} !== 5'b10000) begin
         mis++;
         $display("FAIL len0_fin got done/err/set/valid/rdy=%b want 10000", {bus.o_done, bus.o_err, bus.o_ram_set, bus.o_rsp_valid, bus.o_req_ready});
      end
      step();
      send(2'b11, 16'h0020, 8'd4, 32'hFFFFFFFF);
      vec++;
      if ({bus.o_done, bus.o_err, bus.o_ram_set, bus.o_rsp_valid, bus.o_req_ready} !== 5'b11000) begin
         mis++;
         $display("FAIL op11_fin got done/err/set/valid/rdy=%b want 11000", {bus.o_done, bus.o_err, bus.o_ram_set, bus.o_rsp_valid, bus.o_req_ready});
      end
      step();
      vec++;
      if ({bus.o_done, bus.o_err, bus.o_req_ready, mem[16'h0020]} !== {3'b001, 32'h0}) begin
         mis++;
         $display("FAIL op11_idle got done/err/rdy=%b mem=%h want 001 00000000", {bus.o_done, bus.o_err, bus.o_req_ready}, mem[16'h0020]);
      end
   endtask

   task automatic test_reset_mid_fill();
      bit seen;
      send(2'b10, 16'h0100, 8'd5, 32'hDEADBEEF);
      step();
      vec++;
      if ({bus.o_ram_set, bus.o_ram_addr} !== {1'b1, 16'h0101}) begin
         mis++;
         $display("FAIL rstfill_c2 got set=%b addr=%h want 1 0101", bus.o_ram_set, bus.o_ram_addr);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      vec++;
      if ({bus.o_ram_set, bus.o_done, bus.o_req_ready} !== 3'b001) begin
         mis++;
         $display("FAIL rstfill_edge got set/done/rdy=%b want 001", {bus.o_ram_set, bus.o_done, bus.o_req_ready});
      end
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         seen |= bus.o_done | bus.o_ram_set;
      end
      vec++;
      if (seen || {mem[16'h0100], mem[16'h0101], mem[16'h0102]} !== {{2{32'hDEADBEEF}}, 32'h0}) begin
         mis++;
         $display("FAIL rstfill_after got stray=%b mem=%h %h %h want 0 DEADBEEF DEADBEEF 00000000",
                  seen, mem[16'h0100], mem[16'h0101], mem[16'h0102]);
      end
      test_write(16'h0200, 32'hCAFEF00D);
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = '0;
      mem[1] = 32'h11111111;
      bus.i_req_valid = 1'b0;
      bus.i_req_op    = 2'b00;
      bus.i_req_addr  = '0;
      bus.i_req_len   = '0;
      bus.i_req_data  = '0;
      bus.i_rsp_ready = 1'b0;
      test_reset();
      test_write(16'h0000, 32'hAAAAAAAA);
      test_fill_read();
      test_backpressure();
      test_wrap();
      test_zero_len_reserved();
      test_reset_mid_fill();
      $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
      $finish;
   end
endmodule
